id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the five-stage MIPS core.
- Captures decoded control, register-file operands, sign-extended immediate and the selected destination register (RT/RD mux output) at the end of ID, and presents them to EX.
- Contains the load-use hazard detector: inserts a bubble into EX and requests a PC/IF-ID freeze.
- Handles external stall and branch flush; keeps a saturating count of load-use bubbles.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_W, 5, register specifier width
- ALUOP_W, 4, ALU operation code width
- CNT_W, 16, bubble counter width

Ports:
- i_clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_stall  in  1  global hold (e.g. memory wait); freezes this register
- i_flush  in  1  branch/jump taken; squash the instruction entering EX
- i_valid  in  1  ID holds a real instruction
- i_pc_plus4  in  DATA_W  PC+4 of the ID instruction
- i_rs_data  in  DATA_W  register file read port A
- i_rt_data  in  DATA_W  register file read port B
- i_imm_ext  in  DATA_W  sign-extended immediate
- i_rs  in  REG_W  ID source specifier rs
- i_rt  in  REG_W  ID source specifier rt
- i_uses_rt  in  1  ID instruction reads rt as a source
- i_dest  in  REG_W  destination from the RT/RD select mux
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src, i_branch  in  1 each  decoded control
- i_alu_op  in  ALUOP_W  decoded ALU op
- o_valid  out  1  EX holds a real instruction
- o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext  out  DATA_W  registered copies
- o_rs, o_rt, o_dest  out  REG_W  registered specifiers (forwarding unit uses o_rs/o_rt)
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_branch  out  1 each  registered control
- o_alu_op  out  ALUOP_W  registered ALU op
- o_hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle
- o_bubble_count  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset: `reset`, asynchronous, active-high; clock `i_clk`. While reset is high, every registered output is 0, including o_bubble_count. o_hazard_stall is 0 because o_valid=0.
- Hazard detect (combinational):
  - o_hazard_stall = o_valid & o_mem_read & (o_dest != 0) & ((o_dest == i_rs) | (i_uses_rt & o_dest == i_rt)).
  - It does not depend on i_valid, i_stall or i_flush.
- Per-edge priority, highest first:
  1. reset: clear everything.
  2. i_flush: bubble. o_valid and all control outputs are set to 0; data/specifier fields hold. o_bubble_count is unchanged. Flush overrides i_stall.
  3. i_stall: every field holds, including o_valid and o_bubble_count.
  4. o_hazard_stall: load-use bubble. Control and o_valid are set to 0; data fields hold. o_bubble_count increments by 1, saturating at 2^CNT_W-1.
  5. Otherwise, load: every output takes its input next edge. o_valid = i_valid. When i_valid=0, control outputs load 0 regardless of the i_* control inputs.
- Latency: one cycle from ID input to EX output.
- Load-use sequence: lw in EX and a dependent op in ID gives exactly one bubble. In the next cycle o_valid=0, so o_hazard_stall drops. The held ID instruction then loads on the following edge.
- Register $0 as destination never raises a hazard.
- Back-to-back: lw followed by a dependent lw gives one bubble each time the condition holds.
- Reset mid-operation clears a pending bubble and the counter immediately, without waiting for a clock edge.

Test Plan:
- Reset, then release with i_valid=1, i_dest=5, i_reg_write=1, i_alu_op=4'h2, i_rs_data=32'h1234 -> after 1 edge: o_valid=1, o_dest=5, o_alu_op=2, o_rs_data=32'h1234, o_hazard_stall=0.
- EX holds lw with o_dest=8, o_mem_read=1; ID has i_rs=8 -> o_hazard_stall=1 the same cycle. Next edge: o_valid=0, o_mem_read=0, o_bubble_count=1, o_hazard_stall=0. Following edge: the dependent instruction loads with o_valid=1.
- EX lw o_dest=0, ID i_rs=0 -> o_hazard_stall=0. EX lw o_dest=9, ID i_rt=9, i_uses_rt=0 -> o_hazard_stall=0. Same with i_uses_rt=1 -> 1.
- i_stall=1 for 3 cycles while inputs change -> all outputs unchanged. Assert i_flush=1 together with i_stall=1 -> next edge o_valid=0, all control 0, o_bubble_count unchanged.
- Preload o_bubble_count to 16'hFFFE via repeated hazards, then trigger 3 more -> count reads 16'hFFFF and stays there.
- Assert reset asynchronously mid-cycle while o_valid=1 and count=3 -> all outputs 0 before the next i_clk edge.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, stall/flush handling
// and a saturating count of inserted load-use bubbles.
module id_ex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               reset,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [DATA_W-1:0]  i_pc_plus4,
  input  logic [DATA_W-1:0]  i_rs_data,
  input  logic [DATA_W-1:0]  i_rt_data,
  input  logic [DATA_W-1:0]  i_imm_ext,
  input  logic [REG_W-1:0]   i_rs,
  input  logic [REG_W-1:0]   i_rt,
  input  logic               i_uses_rt,
  input  logic [REG_W-1:0]   i_dest,
  input  logic               i_reg_write,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_mem_to_reg,
  input  logic               i_alu_src,
  input  logic               i_branch,
  input  logic [ALUOP_W-1:0] i_alu_op,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_pc_plus4,
  output logic [DATA_W-1:0]  o_rs_data,
  output logic [DATA_W-1:0]  o_rt_data,
  output logic [DATA_W-1:0]  o_imm_ext,
  output logic [REG_W-1:0]   o_rs,
  output logic [REG_W-1:0]   o_rt,
  output logic [REG_W-1:0]   o_dest,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_to_reg,
  output logic               o_alu_src,
  output logic               o_branch,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic               o_hazard_stall,
  output logic [CNT_W-1:0]   o_bubble_count
);

  logic               r_valid;
  logic [DATA_W-1:0]  r_pc_plus4;
  logic [DATA_W-1:0]  r_rs_data;
  logic [DATA_W-1:0]  r_rt_data;
  logic [DATA_W-1:0]  r_imm_ext;
  logic [REG_W-1:0]   r_rs;
  logic [REG_W-1:0]   r_rt;
  logic [REG_W-1:0]   r_dest;
  logic               r_reg_write;
  logic               r_mem_read;
  logic               r_mem_write;
  logic               r_mem_to_reg;
  logic               r_alu_src;
  logic               r_branch;
  logic [ALUOP_W-1:0] r_alu_op;
  logic [CNT_W-1:0]   r_bubble_count;

  logic w_dest_nonzero;
  logic w_dest_match;
  logic w_hazard;
  logic w_cnt_sat;

  // A load in EX whose result is needed by ID cannot be forwarded in time;
  // writes to $0 are discarded, so they never create a dependency.
  assign w_dest_nonzero = (r_dest != '0);
  assign w_dest_match   = (r_dest == i_rs) | (i_uses_rt & (r_dest == i_rt));
  assign w_hazard       = r_valid & r_mem_read & w_dest_nonzero & w_dest_match;
  assign w_cnt_sat      = &r_bubble_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_pc_plus4     <= '0;
      r_rs_data      <= '0;
      r_rt_data      <= '0;
      r_imm_ext      <= '0;
      r_rs           <= '0;
      r_rt           <= '0;
      r_dest         <= '0;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_alu_src      <= 1'b0;
      r_branch       <= 1'b0;
      r_alu_op       <= '0;
      r_bubble_count <= '0;
    end else if (i_flush) begin
      // Squash wins over a global hold; data fields are don't-care once invalid.
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_op     <= '0;
    end else if (!i_stall) begin
      if (w_hazard) begin
        r_valid      <= 1'b0;
        r_reg_write  <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
        r_alu_src    <= 1'b0;
        r_branch     <= 1'b0;
        r_alu_op     <= '0;
        if (!w_cnt_sat) begin
          r_bubble_count <= r_bubble_count + 1'b1;
        end
      end else begin
        r_valid      <= i_valid;
        r_pc_plus4   <= i_pc_plus4;
        r_rs_data    <= i_rs_data;
        r_rt_data    <= i_rt_data;
        r_imm_ext    <= i_imm_ext;
        r_rs         <= i_rs;
        r_rt         <= i_rt;
        r_dest       <= i_dest;
        r_reg_write  <= i_valid & i_reg_write;
        r_mem_read   <= i_valid & i_mem_read;
        r_mem_write  <= i_valid & i_mem_write;
        r_mem_to_reg <= i_valid & i_mem_to_reg;
        r_alu_src    <= i_valid & i_alu_src;
        r_branch     <= i_valid & i_branch;
        r_alu_op     <= i_valid ? i_alu_op : '0;
      end
    end
  end

  assign o_valid        = r_valid;
  assign o_pc_plus4     = r_pc_plus4;
  assign o_rs_data      = r_rs_data;
  assign o_rt_data      = r_rt_data;
  assign o_imm_ext      = r_imm_ext;
  assign o_rs           = r_rs;
  assign o_rt           = r_rt;
  assign o_dest         = r_dest;
  assign o_reg_write    = r_reg_write;
  assign o_mem_read     = r_mem_read;
  assign o_mem_write    = r_mem_write;
  assign o_mem_to_reg   = r_mem_to_reg;
  assign o_alu_src      = r_alu_src;
  assign o_branch       = r_branch;
  assign o_alu_op       = r_alu_op;
  assign o_hazard_stall = w_hazard;
  assign o_bubble_count = r_bubble_count;

endmodule
